draw_scheduler: RTL and testbench

Sequencing controller that owns the single framebuffer write port of the VGA line-drawing path. Arbitrates between a full-screen clear sweep and line-draw commands. Hands accepted commands to the line drawer through a start/done handshake and forwards the drawer's pixel writes. Sits between the user/command source and the VGA framebuffer, wrapping the line drawer.

---
 rtl/draw_pkg.sv | 16 +
 rtl/draw_scheduler_raster_counter.sv | 45 ++++
 rtl/draw_scheduler.sv | 151 +++++++++++++++
 tb/tb_draw_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared state encoding and default screen geometry for the draw scheduler.
package draw_pkg;

  localparam int DFLT_X_MAX = 640;
  localparam int DFLT_Y_MAX = 480;
  localparam int DFLT_XW    = 10;
  localparam int DFLT_YW    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    DRAW  = 2'd3
  } state_t;

endpackage

// File: rtl/draw_scheduler_raster_counter.sv
// Raster sweep counter for the clear pass: x fastest, wraps to (0,0) after the last pixel.
module raster_counter
  import draw_pkg::*;
#(
  parameter int X_MAX = DFLT_X_MAX,
  parameter int Y_MAX = DFLT_Y_MAX,
  parameter int XW    = DFLT_XW,
  parameter int YW    = DFLT_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          restart,
  input  logic          en,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX - 1);

  // Sweep position; restart takes priority over advancing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (restart) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end else begin
      cx <= cx;
      cy <= cy;
    end
  end

  assign last = (cx == X_LAST) && (cy == Y_LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Owns the framebuffer write port: arbitrates a full-screen clear sweep against
// line commands, hands commands to the line drawer and forwards its pixels.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int X_MAX = DFLT_X_MAX,
  parameter int Y_MAX = DFLT_Y_MAX,
  parameter int XW    = DFLT_XW,
  parameter int YW    = DFLT_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_req,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [XW-1:0] cmd_x1,
  input  logic [YW-1:0] cmd_y0,
  input  logic [YW-1:0] cmd_y1,
  input  logic          cmd_color,
  output logic          ld_start,
  output logic [XW-1:0] ld_x0,
  output logic [XW-1:0] ld_x1,
  output logic [YW-1:0] ld_y0,
  output logic [YW-1:0] ld_y1,
  input  logic [XW-1:0] ld_x,
  input  logic [YW-1:0] ld_y,
  input  logic          ld_we,
  input  logic          ld_done,
  output logic [XW-1:0] fb_x,
  output logic [YW-1:0] fb_y,
  output logic          fb_color,
  output logic          fb_we,
  output logic          busy,
  output logic          clearing
);

  localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          clear_pend_r;
  logic          color_r;
  logic          restart_s;
  logic          accept_s;
  logic          last_s;
  logic [XW-1:0] cx_s;
  logic [YW-1:0] cy_s;

  raster_counter #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX),
    .XW   (XW),
    .YW   (YW)
  ) u_raster (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(restart_s),
    .en     (state_r == CLEAR),
    .cx     (cx_s),
    .cy     (cy_s),
    .last   (last_s)
  );

  assign cmd_ready = (state_r == IDLE) && !clear_req && !clear_pend_r;
  assign accept_s  = cmd_valid && cmd_ready;
  assign busy      = (state_r != IDLE);
  assign clearing  = (state_r == CLEAR);

  // Next state; a clear request always beats a command, and the drawer is never cut short.
  always_comb begin
    state_nxt_s = state_r;
    restart_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_req || clear_pend_r) state_nxt_s = CLEAR;
        else if (cmd_valid)            state_nxt_s = ISSUE;
        else                           state_nxt_s = IDLE;
      end
      CLEAR: begin
        if (clear_req)   state_nxt_s = CLEAR;
        else if (last_s) state_nxt_s = IDLE;
        else             state_nxt_s = CLEAR;
      end
      ISSUE: state_nxt_s = DRAW;
      DRAW: begin
        if (ld_done) state_nxt_s = (clear_pend_r || clear_req) ? CLEAR : IDLE;
        else         state_nxt_s = DRAW;
      end
      default: state_nxt_s = IDLE;
    endcase
    restart_s = (state_nxt_s == CLEAR) && ((state_r != CLEAR) || clear_req);
  end

  // State, deferred-clear flag and the registered command handed to the drawer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      clear_pend_r <= 1'b0;
      ld_start     <= 1'b0;
      ld_x0        <= '0;
      ld_x1        <= '0;
      ld_y0        <= '0;
      ld_y1        <= '0;
      color_r      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ld_start <= accept_s;
      if (state_nxt_s == CLEAR)                                   clear_pend_r <= 1'b0;
      else if (clear_req && (state_r == ISSUE || state_r == DRAW)) clear_pend_r <= 1'b1;
      else                                                        clear_pend_r <= clear_pend_r;
      if (accept_s) begin
        ld_x0   <= cmd_x0;
        ld_x1   <= cmd_x1;
        ld_y0   <= cmd_y0;
        ld_y1   <= cmd_y1;
        color_r <= cmd_color;
      end else begin
        color_r <= color_r;
      end
    end
  end

  // Framebuffer port register; drawer pixels outside the screen are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
      fb_we    <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          fb_x     <= cx_s;
          fb_y     <= cy_s;
          fb_color <= 1'b0;
          fb_we    <= 1'b1;
        end
        DRAW: begin
          fb_x     <= ld_x;
          fb_y     <= ld_y;
          fb_color <= color_r;
          fb_we    <= ld_we && (ld_x < X_LIM) && (ld_y < Y_LIM);
        end
        default: fb_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: a write-stream model derived from the screen rules,
// a stub line drawer, and literal timing checks. Geometry is shrunk to keep clears short.
`timescale 1ns/1ps
module tb_draw_scheduler;

  localparam int XM   = 32;
  localparam int YM   = 24;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int NPIX = XM * YM;

  logic          clk = 1'b0;
  logic          reset_n, clear_req, cmd_valid, cmd_ready, cmd_color;
  logic [XW-1:0] cmd_x0, cmd_x1, ld_x0, ld_x1, ld_x, fb_x;
  logic [YW-1:0] cmd_y0, cmd_y1, ld_y0, ld_y1, ld_y, fb_y;
  logic          ld_start, ld_we, ld_done, fb_color, fb_we, busy, clearing;

  typedef struct {int x; int y; int c;} wr_t;
  wr_t exp_q[$];
  int  drw_x[$];
  int  drw_y[$];
  int  checks = 0, errors = 0, wr_count = 0, start_count = 0, pix_sent = 0;

  always #5 clk = ~clk;

  draw_scheduler #(.X_MAX(XM), .Y_MAX(YM), .XW(XW), .YW(YW)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .ld_start(ld_start), .ld_x0(ld_x0), .ld_x1(ld_x1), .ld_y0(ld_y0), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y), .ld_we(ld_we), .ld_done(ld_done),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we),
    .busy(busy), .clearing(clearing)
  );

  task automatic finish_bench();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      if (errors >= 40) finish_bench();
    end
  endtask

  // Every pixel of the screen, row by row, in colour 0.
  task automatic push_clear();
    wr_t e;
    for (int n = 0; n < NPIX; n++) begin
      e.x = n % XM; e.y = n / XM; e.c = 0;
      exp_q.push_back(e);
    end
  endtask

  // Drawer pixels that land on the screen, in the command colour.
  task automatic push_draw(input int c);
    wr_t e;
    for (int i = 0; i < drw_x.size(); i++) begin
      if (drw_x[i] < XM && drw_y[i] < YM) begin
        e.x = drw_x[i]; e.y = drw_y[i]; e.c = c;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic issue_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_x0 = XW'(x0); cmd_x1 = XW'(x1); cmd_y0 = YW'(y0); cmd_y1 = YW'(y1);
    cmd_color = c[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard: every framebuffer write must be the next one the model predicts.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n === 1'b1) begin
      if (ld_start === 1'b1) start_count++;
      if (fb_we === 1'b1) begin
        wr_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=(%0d,%0d) required no write", fb_x, fb_y);
        end else begin
          e = exp_q.pop_front();
          if (fb_x !== XW'(e.x) || fb_y !== YW'(e.y) || fb_color !== e.c[0]) begin
            errors++;
            $display("FAIL fb_write actual=(%0d,%0d,c%0d) expected=(%0d,%0d,c%0d)",
                     fb_x, fb_y, fb_color, e.x, e.y, e.c);
          end
        end
        if (errors >= 40) finish_bench();
      end
    end
  end

  // Stub line drawer: plays the current pixel list after each start pulse, then ld_done.
  initial begin
    ld_we = 1'b0; ld_done = 1'b0; ld_x = '0; ld_y = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && ld_start === 1'b1) begin
        @(posedge clk); #1;
        for (int i = 0; i < drw_x.size(); i++) begin
          ld_we = 1'b1; ld_x = XW'(drw_x[i]); ld_y = YW'(drw_y[i]);
          pix_sent = i + 1;
          @(posedge clk); #1;
        end
        ld_we = 1'b0; ld_done = 1'b1;
        @(posedge clk); #1;
        ld_done = 1'b0;
      end
    end
  end

  initial begin
    #(10 * 20000);
    errors++;
    $display("FAIL watchdog actual=timeout required=completion");
    finish_bench();
  end

  initial begin
    int w0, s0, n, gap;
    reset_n = 1'b0; clear_req = 1'b1; cmd_valid = 1'b0; cmd_color = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
    #12;
    check("rst_fb_we", {31'd0, fb_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clearing", {31'd0, clearing}, 32'd0);
    check("rst_ld_start", {31'd0, ld_start}, 32'd0);
    check("rst_ld_regs", {ld_x0, ld_x1, ld_y0[5:0], ld_y1[5:0]}, 32'd0);
    check("rst_cmd_ready_req", {31'd0, cmd_ready}, 32'd0);
    clear_req = 1'b0; #1;
    check("rst_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    // Full clear with literal timing of first and last writes.
    push_clear();
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    w0 = wr_count;
    @(negedge clk);
    check("clr_clearing", {31'd0, clearing}, 32'd1);
    check("clr_no_write_yet", {31'd0, fb_we}, 32'd0);
    @(negedge clk);
    check("clr_first_we", {31'd0, fb_we}, 32'd1);
    check("clr_first_xy", {fb_x, 13'd0, fb_y}, 32'd0);
    repeat (NPIX - 1) @(negedge clk);
    check("clr_last_we", {31'd0, fb_we}, 32'd1);
    check("clr_last_x", {22'd0, fb_x}, 32'd31);
    check("clr_last_y", {23'd0, fb_y}, 32'd23);
    check("clr_busy_after", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("clr_we_after", {31'd0, fb_we}, 32'd0);
    check("clr_count", wr_count - w0, NPIX);

    // Single horizontal line (10,20)->(15,20), colour 1.
    drw_x = '{10, 11, 12, 13, 14, 15}; drw_y = '{20, 20, 20, 20, 20, 20};
    push_draw(1);
    w0 = wr_count; s0 = start_count;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_x0 = 10'd10; cmd_x1 = 10'd15; cmd_y0 = 9'd20; cmd_y1 = 9'd20; cmd_color = 1'b1;
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("cmd_ld_start", {31'd0, ld_start}, 32'd1);
    check("cmd_ld_x", {6'd0, ld_x0, 6'd0, ld_x1}, {6'd0, 10'd10, 6'd0, 10'd15});
    check("cmd_ld_y", {7'd0, ld_y0, 7'd0, ld_y1}, {7'd0, 9'd20, 7'd0, 9'd20});
    check("cmd_busy", {30'd0, busy, clearing}, 32'd2);
    @(negedge clk);
    check("cmd_start_one_cycle", {31'd0, ld_start}, 32'd0);
    wait_idle("cmd", 40);
    check("cmd_writes", wr_count - w0, 6);
    check("cmd_starts", start_count - s0, 1);

    // Clear and command in the same cycle: clear wins, command follows.
    push_clear();
    drw_x = '{2, 3, 4}; drw_y = '{7, 7, 7};
    push_draw(1);
    s0 = start_count;
    @(posedge clk); #1;
    clear_req = 1'b1; cmd_valid = 1'b1;
    cmd_x0 = 10'd2; cmd_x1 = 10'd4; cmd_y0 = 9'd7; cmd_y1 = 9'd7; cmd_color = 1'b1;
    @(negedge clk);
    check("both_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk);
    check("both_clear_first", {30'd0, clearing, ld_start}, 32'd2);
    n = 0;
    while (ld_start !== 1'b1 && n < NPIX + 20) begin
      @(negedge clk);
      n++;
    end
    check("both_start_seen", {31'd0, ld_start}, 32'd1);
    check("both_clear_done_first", exp_q.size(), 3);
    cmd_valid = 1'b0;
    wait_idle("both", 40);
    check("both_starts", start_count - s0, 1);

    // Clear requested mid-draw: drawer finishes, clear follows with no idle gap.
    drw_x = '{0, 1, 2, 3, 4, 5, 6, 7}; drw_y = '{5, 5, 5, 5, 5, 5, 5, 5};
    push_draw(1);
    push_clear();
    w0 = wr_count; pix_sent = 0;
    issue_cmd(0, 5, 7, 5, 1);
    n = 0;
    while (pix_sent < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("mid_pixels_started", pix_sent >= 3, 32'd1);
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    gap = 0; n = 0;
    while (clearing !== 1'b1 && n < 40) begin
      @(negedge clk);
      if (busy !== 1'b1) gap = 1;
      n++;
    end
    check("mid_clear_entered", {31'd0, clearing}, 32'd1);
    check("mid_no_idle_gap", gap, 0);
    wait_idle("mid", NPIX + 50);
    check("mid_writes", wr_count - w0, 8 + NPIX);

    // Off-screen drawer pixels are dropped, edge pixels kept.
    drw_x = '{645, 3, 31, 32, 0, 7}; drw_y = '{5, 480, 23, 0, 24, 7};
    push_draw(0);
    w0 = wr_count;
    issue_cmd(0, 0, 7, 7, 0);
    wait_idle("oob", 40);
    check("oob_writes", wr_count - w0, 2);
    check("queue_drained", exp_q.size(), 0);

    // Reset part-way through a clear abandons it.
    push_clear();
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    w0 = wr_count; n = 0;
    while (wr_count - w0 < 100 && n < 2 * NPIX) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_progress", wr_count - w0 >= 100, 32'd1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstmid_fb_we", {31'd0, fb_we}, 32'd0);
    check("rstmid_state", {30'd0, busy, clearing}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    w0 = wr_count;
    repeat (40) @(negedge clk);
    check("rstmid_no_writes", wr_count - w0, 0);
    check("rstmid_idle", {31'd0, busy}, 32'd0);

    finish_bench();
  end

endmodule
